// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encoding and default parameters for the execute stage
package alu_pkg;
    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        SLT = 3'b101,
        SLL = 3'b110,
        SRL = 3'b111
    } alu_op_e;
    localparam int XLEN_DEF     = 32;
    localparam int NREG_DEF     = 32;
    localparam int A0_IDX_DEF   = 10;
    localparam int TRIG_IDX_DEF = 5;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational integer ALU on resolved operands
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  alu_op_e         i_op,
    output logic [XLEN-1:0] o_result
);
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] w_shamt;
    assign w_shamt = i_src_b[SW-1:0];
    always_comb begin
        o_result = (i_op == ADD) ? i_src_a + i_src_b :
                   (i_op == SUB) ? i_src_a - i_src_b :
                   (i_op == AND) ? i_src_a & i_src_b :
                   (i_op == OR)  ? i_src_a | i_src_b :
                   (i_op == XOR) ? i_src_a ^ i_src_b :
                   (i_op == SLT) ? XLEN'($signed(i_src_a) < $signed(i_src_b)) :
                   (i_op == SLL) ? i_src_a << w_shamt :
                                   i_src_a >> w_shamt;
    end
endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file, operand forwarding, ALU and handshaked output stage
module alu_regfile_pipe
    import alu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int A0_IDX   = A0_IDX_DEF,
    parameter int TRIG_IDX = TRIG_IDX_DEF,
    parameter int FWD_EN   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            ALUSrc,
    input  logic [2:0]      ALUControl,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] ImmOp,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] WriteData,
    output logic            Zero,
    output logic [AW-1:0]   out_rd,
    output logic            out_RegWrite,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            trigger,
    output logic [XLEN-1:0] a0
);
    logic [XLEN-1:0] r_regs [NREG];
    logic            r_out_valid;
    logic            r_out_regwrite;
    logic            r_zero;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_wdata;
    logic [AW-1:0]   r_out_rd;
    logic            w_accept;
    logic            w_fwd_ok;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_result;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_fwd_ok = (FWD_EN != 0) && r_out_valid && r_out_regwrite;

    // out-of-range addresses only occur when NREG is not a power of two
    always_comb begin
        w_op_a = (rs1 == '0 || int'(rs1) >= NREG) ? '0 :
                 (w_fwd_ok && r_out_rd == rs1)    ? r_alu :
                 (wb_en && wb_rd == rs1)          ? wb_data :
                                                    r_regs[rs1];
        w_op_b = (rs2 == '0 || int'(rs2) >= NREG) ? '0 :
                 (w_fwd_ok && r_out_rd == rs2)    ? r_alu :
                 (wb_en && wb_rd == rs2)          ? wb_data :
                                                    r_regs[rs2];
        w_src_b = ALUSrc ? ImmOp : w_op_b;
    end

    alu_core #(.XLEN(XLEN)) u_alu (
        .i_src_a  (w_op_a),
        .i_src_b  (w_src_b),
        .i_op     (alu_op_e'(ALUControl)),
        .o_result (w_result)
    );

    // x0 is never written; writeback beats the trigger on TRIG_IDX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                r_regs[i] <= (wb_en && int'(wb_rd) == i) ? wb_data :
                             (i == TRIG_IDX)             ? XLEN'(trigger) :
                                                           r_regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_alu          <= '0;
            r_wdata        <= '0;
            r_zero         <= 1'b0;
            r_out_rd       <= '0;
            r_out_regwrite <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_alu          <= w_result;
            r_wdata        <= w_op_b;
            r_zero         <= (w_result == '0);
            r_out_rd       <= rd;
            r_out_regwrite <= RegWrite;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign ALUResult    = r_alu;
    assign WriteData    = r_wdata;
    assign Zero         = r_zero;
    assign out_rd       = r_out_rd;
    assign out_RegWrite = r_out_regwrite;
    assign a0           = r_regs[A0_IDX];
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: directed vectors with a queue scoreboard checked by an output monitor
module tb_alu_regfile_pipe;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid, in_ready, ALUSrc, RegWrite, flush;
    logic [2:0]      ALUControl;
    logic [AW-1:0]   rs1, rs2, rd, out_rd, wb_rd;
    logic [XLEN-1:0] ImmOp, ALUResult, WriteData, wb_data, a0;
    logic            out_valid, out_ready, Zero, out_RegWrite, wb_en, trigger;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   rd;
        logic            rw;
    } exp_t;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_regfile_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUSrc(ALUSrc), .ALUControl(ALUControl), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .ImmOp(ImmOp), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .WriteData(WriteData), .Zero(Zero),
        .out_rd(out_rd), .out_RegWrite(out_RegWrite), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .trigger(trigger), .a0(a0)
    );

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en = 1'b1; wb_rd = a; wb_data = d;
        wait_cyc(1);
        wb_en = 1'b0;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                         input logic src, input logic [2:0] op, input logic [XLEN-1:0] imm, input logic rw);
        in_valid = 1'b1; rs1 = a; rs2 = b; rd = d;
        ALUSrc = src; ALUControl = op; ImmOp = imm; RegWrite = rw;
    endtask

    task automatic accept(input logic push, input logic [XLEN-1:0] res, input logic [XLEN-1:0] wd);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end else if (push) begin
            q.push_back('{res, wd, rd, RegWrite});
        end
        wait_cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                         input logic src, input logic [2:0] op, input logic [XLEN-1:0] imm, input logic rw,
                         input logic [XLEN-1:0] res, input logic [XLEN-1:0] wd);
        drive(a, b, d, src, op, imm, rw);
        accept(1'b1, res, wd);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got res=%h rd=%0d with no expected entry", ALUResult, out_rd);
                end else begin
                    e = q.pop_front();
                    if (ALUResult !== e.res || WriteData !== e.wd || Zero !== (e.res == '0) ||
                        out_rd !== e.rd || out_RegWrite !== e.rw) begin
                        errors++;
                        $display("FAIL result: got res=%h wd=%h z=%b rd=%0d rw=%b expected res=%h wd=%h z=%b rd=%0d rw=%b",
                                 ALUResult, WriteData, Zero, out_rd, out_RegWrite,
                                 e.res, e.wd, (e.res == '0), e.rd, e.rw);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        in_valid = 0; ALUSrc = 0; ALUControl = 0; rs1 = 0; rs2 = 0; rd = 0; RegWrite = 0;
        ImmOp = 0; flush = 0; out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0; trigger = 0;
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_a0", a0, 0);
        chk("reset_alu", ALUResult, 0);
        chk("reset_in_ready", in_ready, 1);
        wait_cyc(1);
        rst = 0;
        wb(1, 5);
        wb(2, 3);
        issue(1, 2, 3, 0, 3'b000, 0, 1, 8, 3);
        chk("latency_valid", out_valid, 1);
        chk("latency_result", ALUResult, 8);
        chk("latency_zero", Zero, 0);
        issue(1, 2, 4, 0, 3'b000, 0, 1, 8, 3);
        issue(4, 1, 7, 0, 3'b001, 0, 1, 3, 5);
        wb_en = 1; wb_rd = 6; wb_data = 32'hFFFF_FFFF;
        issue(6, 0, 8, 0, 3'b101, 0, 0, 1, 0);
        wb_en = 1; wb_rd = 9; wb_data = 32'hFFFF_FFFF;
        issue(9, 0, 9, 1, 3'b111, 4, 0, 32'h0FFF_FFFF, 0);
        wb_en = 0;
        issue(1, 0, 13, 1, 3'b010, 6, 1, 4, 0);
        issue(1, 0, 13, 1, 3'b011, 10, 1, 15, 0);
        issue(1, 1, 14, 0, 3'b100, 0, 1, 0, 5);
        issue(2, 0, 15, 1, 3'b110, 4, 1, 48, 0);
        issue(2, 1, 16, 0, 3'b001, 0, 1, 32'hFFFF_FFFE, 5);
        issue(2, 1, 17, 0, 3'b101, 0, 0, 1, 5);
        issue(1, 6, 17, 0, 3'b101, 0, 0, 0, 32'hFFFF_FFFF);
        wait_cyc(2);
        out_ready = 0;
        issue(1, 0, 11, 1, 3'b000, 100, 0, 105, 0);
        drive(1, 0, 12, 1, 3'b000, 200, 0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_result", ALUResult, 105);
            wait_cyc(1);
        end
        out_ready = 1;
        accept(1, 205, 0);
        chk("release_result", ALUResult, 205);
        flush = 1;
        drive(1, 2, 12, 0, 3'b000, 0, 1);
        accept(0, 0, 0);
        flush = 0;
        chk("flush_kill", out_valid, 0);
        wb(0, 32'hDEAD);
        issue(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        trigger = 1;
        wait_cyc(1);
        issue(5, 0, 0, 0, 3'b000, 0, 0, 1, 0);
        wb(5, 7);
        issue(5, 0, 0, 0, 3'b000, 0, 0, 7, 0);
        trigger = 0;
        wb_en = 1; wb_rd = 10; wb_data = 32'h1234;
        @(negedge clk);
        chk("a0_before", a0, 0);
        wait_cyc(1);
        wb_en = 0;
        chk("a0_after", a0, 32'h1234);
        out_ready = 0;
        drive(1, 2, 18, 0, 3'b000, 0, 1);
        accept(0, 0, 0);
        wait_cyc(2);
        chk("hold_before_rst", out_valid, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_a0", a0, 0);
        chk("async_rst_alu", ALUResult, 0);
        wait_cyc(1);
        rst = 0;
        out_ready = 1;
        wait_cyc(3);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU + register-file execute path.
- Holds the integer register file. Reads operands, selects register or immediate for SrcB, and computes the ALU result.
- Registers the result into an output stage with a valid/ready handshake, a flush input, and operand forwarding.
- Sits between decode and memory/writeback. The writeback port returns results from later stages.

Parameters:
- XLEN, 32, datapath width in bits.
- NREG, 32, number of architectural registers; x0 is hardwired to zero; address width is AW = $clog2(NREG).
- A0_IDX, 10, register index mirrored on the a0 output.
- TRIG_IDX, 5, register index updated from the trigger input.
- FWD_EN, 1, 1 enables output-stage-to-input forwarding; 0 means the consumer must stall externally.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- ALUSrc  in  1  1 selects ImmOp for SrcB, 0 selects rs2 data
- ALUControl  in  3  ALU operation
- rs1, rs2  in  AW  source register addresses
- rd  in  AW  destination register address
- RegWrite  in  1  instruction will write rd (used for forwarding tag)
- ImmOp  in  XLEN  immediate operand
- flush  in  1  kill the output-stage contents
- out_valid  out  1  output stage holds a valid result
- out_ready  in  1  downstream accepts the result
- ALUResult  out  XLEN  registered ALU result
- WriteData  out  XLEN  registered rs2 data (store data)
- Zero  out  1  registered (ALUResult == 0)
- out_rd  out  AW  registered rd
- out_RegWrite  out  1  registered RegWrite
- wb_en  in  1  writeback enable
- wb_rd  in  AW  writeback address
- wb_data  in  XLEN  writeback data
- trigger  in  1  external trigger
- a0  out  XLEN  contents of register A0_IDX

Behaviour:
- Reset (async, active-high): all registers, out_valid, ALUResult, WriteData, Zero, out_rd, out_RegWrite and a0 go to 0. An instruction in flight is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready. The result appears on the outputs with out_valid=1 on the next edge (latency 1).
  - While out_valid && !out_ready, all outputs hold stable.
  - If out_ready && !accept, out_valid clears on the next edge.
- flush: on the next edge out_valid=0 and any same-cycle accept is discarded. flush has priority over accept. Data outputs may keep stale values.
- Operand resolution, per source rs (highest priority first):
  - (1) rs==0 gives 0.
  - (2) FWD_EN && out_valid && out_RegWrite && out_rd==rs gives ALUResult.
  - (3) wb_en && wb_rd==rs gives wb_data (write-through bypass).
  - (4) otherwise the register file entry.
- ALU, combinational on the resolved operands (SrcA = rs1 operand, SrcB = ALUSrc ? ImmOp : rs2 operand):
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt: signed compare; result is {XLEN-1 zeros, lt}
  - 110 sll, 111 srl: shift amount is SrcB[$clog2(XLEN)-1:0]
  - Results wrap modulo 2^XLEN; there is no overflow flag.
- Register file writes:
  - wb_en && wb_rd!=0 writes wb_data on the edge.
  - Writes to x0 are ignored.
  - The trigger write, {XLEN-1 zeros, trigger} into TRIG_IDX, happens every cycle unless wb_en && wb_rd==TRIG_IDX that cycle; writeback wins.
- a0: mirrors register A0_IDX and reflects a write on the cycle after the edge.
- NREG not a power of two: reads of addresses >= NREG return 0 and writes to them are ignored.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e with ADD, SUB, AND, OR, XOR, SLT, SLL, SRL
  - default constants XLEN_DEF, NREG_DEF, A0_IDX_DEF, TRIG_IDX_DEF
- Sub-module alu_core: purely combinational, parametrised by XLEN; inputs SrcA, SrcB and alu_op_e; outputs the result.
- The register file, forwarding mux and output stage stay in alu_regfile_pipe.

Test Plan:
- Reset, then wb x1=5 and wb x2=3. Issue add x3 (rs1=1, rs2=2, ALUSrc=0, out_ready=1) -> next cycle out_valid=1, ALUResult=8, Zero=0.
- Back-to-back dependency: add rd=4=x1+x2, then sub rs1=4 rs2=1 (FWD_EN=1) -> second ALUResult=3, taken from forwarding.
- Same-cycle wb x6=0xFFFF_FFFF while issuing slt rs1=6 rs2=0 -> ALUResult=1 (bypass, signed -1<0). Same with srl by ImmOp=4 -> 0x0FFF_FFFF.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Release -> the next instruction appears 1 cycle later, with none lost or duplicated.
- flush asserted in the same cycle as an accept -> out_valid=0 next cycle. Writes to x0 leave reads of x0 at 0.
- trigger=1 -> x5 reads 1. wb x5=7 with trigger=1 in the same cycle -> x5=7. wb x10=0x1234 -> a0=0x1234 one cycle later. Async rst mid-stall -> out_valid=0 and a0=0 immediately.
